pixel_filter: RTL and testbench

Parametrised frame-based pixel filter between the UART receiver and transmitter.
- Collects a frame of N pixels from the RX side and applies a run-time-selectable point or 3-tap operation.
- Streams the results back one pixel per TX completion.
- Returns to receiving for the next frame, so multi-frame operation needs no reset.

---
 rtl/pixel_filter_pkg.sv | 17 +
 rtl/pixel_filter_if.sv | 25 ++
 rtl/pixel_filter_op.sv | 42 ++++
 rtl/pixel_filter.sv | 138 +++++++++++++
 tb/tb_pixel_filter.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/pixel_filter_pkg.sv
// Shared types for the pixel_filter frame filter.
// BOX3 support is built only when PIXEL_FILTER_BOX3_EN is defined.
package pixel_filter_pkg;

    typedef enum logic [0:0] {
        RECV,
        SEND
    } state_t;

    typedef enum logic [1:0] {
        MODE_PASS,
        MODE_SHIFT,
        MODE_INVERT,
        MODE_BOX3
    } mode_t;

endpackage

// File: rtl/pixel_filter_if.sv
// RX/TX side bundle of pixel_filter.
// The master drives pixels and acknowledgements; the slave is the filter.
interface pixel_filter_if #(
    parameter int D_BITS = 8
);
    logic [D_BITS-1:0] i_data;
    logic              i_rx_done;
    logic              i_tx_done;
    logic [1:0]        i_mode;
    logic [D_BITS-1:0] o_data;
    logic              o_tx_enable;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_overrun;

    modport master (
        output i_data, i_rx_done, i_tx_done, i_mode,
        input  o_data, o_tx_enable, o_busy, o_frame_done, o_overrun
    );

    modport slave (
        input  i_data, i_rx_done, i_tx_done, i_mode,
        output o_data, o_tx_enable, o_busy, o_frame_done, o_overrun
    );
endinterface

// File: rtl/pixel_filter_op.sv
// Combinational point / 3-tap pixel operation.
// The BOX3 adder exists only with PIXEL_FILTER_BOX3_EN defined.
module pixel_filter_op
    import pixel_filter_pkg::*;
#(
    parameter int D_BITS = 8,
    parameter int SHIFT  = 1
) (
    input  logic [D_BITS-1:0] left_i,
    input  logic [D_BITS-1:0] centre_i,
    input  logic [D_BITS-1:0] right_i,
    input  mode_t             mode_i,
    output logic [D_BITS-1:0] pix_o
);

`ifdef PIXEL_FILTER_BOX3_EN
    // Two guard bits make the 1-2-1 sum overflow-free.
    logic [D_BITS+1:0] sum;
    assign sum = {2'b00, left_i}
               + {1'b0, centre_i, 1'b0}
               + {2'b00, right_i};
`else
    logic unused_nb;
    assign unused_nb = ^{left_i, right_i};
`endif

    always_comb begin
        pix_o = centre_i;
        unique case (mode_i)
            MODE_PASS:   pix_o = centre_i;
            MODE_SHIFT:  pix_o = centre_i >> SHIFT;
            MODE_INVERT: pix_o = ~centre_i;
`ifdef PIXEL_FILTER_BOX3_EN
            MODE_BOX3:   pix_o = sum[D_BITS+1:2];
`else
            MODE_BOX3:   pix_o = centre_i;
`endif
            default:     pix_o = centre_i;
        endcase
    end

endmodule

// File: rtl/pixel_filter.sv
// Frame-based pixel filter: collect N pixels, then stream filtered results.
// Define PIXEL_FILTER_BOX3_EN to build the 3-tap BOX3 mode.
module pixel_filter
    import pixel_filter_pkg::*;
#(
    parameter int D_BITS = 8,
    parameter int N      = 16,
    parameter int SHIFT  = 1
) (
    input logic            i_clk,
    input logic            i_rst_n,
    pixel_filter_if.slave  bus
);

    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [IW-1:0]     wr_q, wr_d;
    logic [IW-1:0]     rd_q, rd_d;
    logic              pend_q, pend_d;
    logic [D_BITS-1:0] data_q, data_d;
    logic              txen_q, txen_d;
    logic              fdone_q, fdone_d;
    logic              ovr_q, ovr_d;
    logic              pix_we;

    logic [D_BITS-1:0] pix_q [N];
    logic [D_BITS-1:0] left, centre, right, op_pix;

    assign centre = pix_q[rd_q];

`ifdef PIXEL_FILTER_BOX3_EN
    // Frame edges replicate the boundary pixel.
    logic [IW-1:0] lidx, ridx;
    assign lidx  = (rd_q == '0)   ? rd_q : rd_q - 1'b1;
    assign ridx  = (rd_q == LAST) ? rd_q : rd_q + 1'b1;
    assign left  = pix_q[lidx];
    assign right = pix_q[ridx];
`else
    assign left  = centre;
    assign right = centre;
`endif

    pixel_filter_op #(
        .D_BITS (D_BITS),
        .SHIFT  (SHIFT)
    ) u_op (
        .left_i   (left),
        .centre_i (centre),
        .right_i  (right),
        .mode_i   (mode_q),
        .pix_o    (op_pix)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        pend_d  = pend_q;
        data_d  = data_q;
        txen_d  = 1'b0;
        fdone_d = 1'b0;
        ovr_d   = 1'b0;
        pix_we  = 1'b0;
        unique case (state_q)
            RECV: begin
                if (bus.i_rx_done) begin
                    pix_we = 1'b1;
                    if (wr_q == '0) mode_d = mode_t'(bus.i_mode);
                    if (wr_q == LAST) begin
                        wr_d    = '0;
                        rd_d    = '0;
                        pend_d  = 1'b0;
                        state_d = SEND;
                    end else begin
                        wr_d = wr_q + 1'b1;
                    end
                end
            end
            SEND: begin
                ovr_d = bus.i_rx_done;
                if (!pend_q) begin
                    data_d = op_pix;
                    txen_d = 1'b1;
                    pend_d = 1'b1;
                end else if (bus.i_tx_done) begin
                    if (rd_q == LAST) begin
                        fdone_d = 1'b1;
                        state_d = RECV;
                    end else begin
                        rd_d   = rd_q + 1'b1;
                        pend_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RECV;
            mode_q  <= MODE_PASS;
            wr_q    <= '0;
            rd_q    <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            txen_q  <= 1'b0;
            fdone_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            txen_q  <= txen_d;
            fdone_q <= fdone_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame storage carries no reset; it is always rewritten before use.
    always_ff @(posedge i_clk) begin
        if (pix_we) pix_q[wr_q] <= bus.i_data;
    end

    assign bus.o_data       = data_q;
    assign bus.o_tx_enable  = txen_q;
    assign bus.o_busy       = (state_q == SEND);
    assign bus.o_frame_done = fdone_q;
    assign bus.o_overrun    = ovr_q;

endmodule

// File: tb/tb_pixel_filter.sv
// Directed self-checking bench for pixel_filter with N=4, SHIFT=1.
module tb_pixel_filter;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pixel_filter_if #(.D_BITS(8)) bif ();

    pixel_filter #(
        .D_BITS (8),
        .N      (4),
        .SHIFT  (1)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixels 0-1 carry mode m_a, pixels 2-3 carry mode m_b.
    task automatic send_frame(input logic [7:0] p0, p1, p2, p3,
                              input logic [1:0] m_a, m_b);
        logic [7:0] p [4];
        p = '{p0, p1, p2, p3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bif.i_data    = p[i];
            bif.i_mode    = (i < 2) ? m_a : m_b;
            bif.i_rx_done = 1'b1;
        end
        @(negedge clk);
        bif.i_rx_done = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [7:0] e0, e1, e2, e3,
                           input int npix, input bit ovr);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < npix; i++) begin
            int t;
            t = 0;
            @(negedge clk);
            while (!bif.o_tx_enable && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk({tag, "_txen"}, 32'(bif.o_tx_enable), 32'd1);
            chk({tag, "_lat"}, 32'(t), 32'd0);
            chk({tag, "_data"}, 32'(bif.o_data), 32'(e[i]));
            chk({tag, "_busy"}, 32'(bif.o_busy), 32'd1);
            bif.i_tx_done = 1'b1;
            if (ovr && i == 1) begin
                bif.i_data    = 8'hEE;
                bif.i_rx_done = 1'b1;
            end
            @(negedge clk);
            bif.i_tx_done = 1'b0;
            bif.i_rx_done = 1'b0;
            chk({tag, "_txen_pulse"}, 32'(bif.o_tx_enable), 32'd0);
            if (ovr && i == 1)
                chk({tag, "_ovr"}, 32'(bif.o_overrun), 32'd1);
            if (i == 3) begin
                chk({tag, "_fdone"}, 32'(bif.o_frame_done), 32'd1);
                chk({tag, "_idle"}, 32'(bif.o_busy), 32'd0);
            end
        end
        if (npix == 4) begin
            @(negedge clk);
            chk({tag, "_fdone_pulse"}, 32'(bif.o_frame_done), 32'd0);
            chk({tag, "_ovr_pulse"}, 32'(bif.o_overrun), 32'd0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bif.i_data    = '0;
        bif.i_rx_done = 1'b0;
        bif.i_tx_done = 1'b0;
        bif.i_mode    = 2'b00;
        #1;
        chk("rst_data", 32'(bif.o_data), 32'd0);
        chk("rst_txen", 32'(bif.o_tx_enable), 32'd0);
        chk("rst_busy", 32'(bif.o_busy), 32'd0);
        chk("rst_fdone", 32'(bif.o_frame_done), 32'd0);
        chk("rst_ovr", 32'(bif.o_overrun), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send_frame(8'd10, 8'd20, 8'd30, 8'd40, 2'b00, 2'b00);
        collect("pass", 8'd10, 8'd20, 8'd30, 8'd40, 4, 1'b0);

        send_frame(8'd255, 8'd8, 8'd3, 8'd0, 2'b01, 2'b01);
        collect("shift", 8'd127, 8'd4, 8'd1, 8'd0, 4, 1'b0);

        send_frame(8'd255, 8'd8, 8'd3, 8'd0, 2'b10, 2'b10);
        collect("invert", 8'd0, 8'd247, 8'd252, 8'd255, 4, 1'b0);

        send_frame(8'd0, 8'd255, 8'd0, 8'd100, 2'b11, 2'b11);
`ifdef PIXEL_FILTER_BOX3_EN
        // Last pixel: (0 + 2*100 + 100) >> 2 with the right edge replicated.
        collect("box3", 8'd63, 8'd127, 8'd88, 8'd75, 4, 1'b0);
`else
        collect("box3", 8'd0, 8'd255, 8'd0, 8'd100, 4, 1'b0);
`endif

        send_frame(8'd1, 8'd2, 8'd3, 8'd4, 2'b00, 2'b00);
        collect("ovr", 8'd1, 8'd2, 8'd3, 8'd4, 4, 1'b1);
        send_frame(8'd5, 8'd6, 8'd7, 8'd8, 2'b10, 2'b10);
        collect("after_ovr", 8'hFA, 8'hF9, 8'hF8, 8'hF7, 4, 1'b0);

        send_frame(8'd11, 8'd22, 8'd33, 8'd44, 2'b00, 2'b10);
        collect("modesw", 8'd11, 8'd22, 8'd33, 8'd44, 4, 1'b0);

        send_frame(8'd50, 8'd60, 8'd70, 8'd80, 2'b00, 2'b00);
        collect("pre_rst", 8'd50, 8'd60, 8'd70, 8'd80, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(bif.o_data), 32'd0);
        chk("arst_busy", 32'(bif.o_busy), 32'd0);
        chk("arst_txen", 32'(bif.o_tx_enable), 32'd0);
        chk("arst_fdone", 32'(bif.o_frame_done), 32'd0);
        chk("arst_ovr", 32'(bif.o_overrun), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'd9, 8'd8, 8'd7, 8'd6, 2'b01, 2'b01);
        collect("post_rst", 8'd4, 8'd4, 8'd3, 8'd3, 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
